// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: FSM states, bank-select one-hots
// and default tick lengths.
package led_seq_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } state_e;

    localparam logic [2:0] ColorRed   = 3'b001;
    localparam logic [2:0] ColorGreen = 3'b010;
    localparam logic [2:0] ColorBlue  = 3'b100;

    localparam int unsigned SpdW = 2;

    localparam int unsigned DefLim0 = 2 ** 20;
    localparam int unsigned DefLim1 = 2 ** 21;
    localparam int unsigned DefLim2 = 2 ** 22;
    localparam int unsigned DefLim3 = 2 ** 23;

    // red -> green -> blue -> red
    function automatic logic [2:0] next_color(input logic [2:0] color);
        return {color[1:0], color[2]};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous level inputs.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: switch-controlled tick generator producing shift strobes,
// shift direction and a rotating red/green/blue bank select.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned N_LED = 4,
    parameter int unsigned CNT_W = 24,
    parameter int unsigned LIM0  = DefLim0,
    parameter int unsigned LIM1  = DefLim1,
    parameter int unsigned LIM2  = DefLim2,
    parameter int unsigned LIM3  = DefLim3
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic [3:0] i_sw,
    output logic       o_valid,
    output logic       o_dir,
    output logic [2:0] o_color,
    output logic       o_busy
);

    localparam int unsigned ShW = (N_LED > 1) ? $clog2(N_LED) : 1;

    localparam logic [CNT_W-1:0] Lim0M1 = CNT_W'(LIM0 - 1);
    localparam logic [CNT_W-1:0] Lim1M1 = CNT_W'(LIM1 - 1);
    localparam logic [CNT_W-1:0] Lim2M1 = CNT_W'(LIM2 - 1);
    localparam logic [CNT_W-1:0] Lim3M1 = CNT_W'(LIM3 - 1);
    localparam logic [ShW-1:0]   ShLast = ShW'(N_LED - 1);

    logic [3:0] sw_s;

    sync_2ff #(
        .Width(4)
    ) u_sync (
        .clk_i (clock),
        .rst_ni(i_reset),
        .d_i   (i_sw),
        .q_o   (sw_s)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ShW-1:0]   shift_q, shift_d;
    logic [2:0]       color_q, color_d;
    logic [SpdW-1:0]  spd_q;
    logic             valid_q, dir_q, dir_d;
    logic             tick, spd_chg;
    logic [CNT_W-1:0] lim_m1;

    assign spd_chg = (sw_s[2:1] != spd_q);

    always_comb begin
        lim_m1 = Lim0M1;
        unique case (spd_q)
            2'd0: lim_m1 = Lim0M1;
            2'd1: lim_m1 = Lim1M1;
            2'd2: lim_m1 = Lim2M1;
            2'd3: lim_m1 = Lim3M1;
            default: lim_m1 = Lim0M1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (sw_s[0])  state_d = StRun;
            StRun:   if (!sw_s[0]) state_d = StPause;
            StPause: if (sw_s[0])  state_d = StRun;
            default: state_d = StIdle;
        endcase

        cnt_d   = cnt_q;
        tick    = 1'b0;
        shift_d = shift_q;
        color_d = color_q;
        dir_d   = dir_q;

        // A speed change restarts the count in any state so it never exceeds the new limit.
        if (spd_chg) begin
            cnt_d = '0;
        end else if (state_q == StRun) begin
            if (cnt_q == lim_m1) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (tick) begin
            dir_d = sw_s[3];
            if (shift_q == ShLast) begin
                shift_d = '0;
                color_d = next_color(color_q);
            end else begin
                shift_d = shift_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            color_q <= ColorRed;
            spd_q   <= '0;
            valid_q <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            color_q <= color_d;
            spd_q   <= sw_s[2:1];
            valid_q <= tick;
            dir_q   <= dir_d;
        end
    end

    assign o_valid = valid_q;
    assign o_dir   = dir_q;
    assign o_color = color_q;
    assign o_busy  = (state_q == StRun);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with short tick lengths (4/8/16/32) and four LEDs.
module tb_led_seq_ctrl;

    logic       clock;
    logic       i_reset;
    logic [3:0] i_sw;
    logic       o_valid;
    logic       o_dir;
    logic [2:0] o_color;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    led_seq_ctrl #(
        .N_LED(4),
        .CNT_W(24),
        .LIM0 (4),
        .LIM1 (8),
        .LIM2 (16),
        .LIM3 (32)
    ) dut (
        .clock  (clock),
        .i_reset(i_reset),
        .i_sw   (i_sw),
        .o_valid(o_valid),
        .o_dir  (o_dir),
        .o_color(o_color),
        .o_busy (o_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] sw;
        int         n;
        int         pulses;
        logic       valid;
        logic       busy;
        logic       dir;
        logic [2:0] color;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n clocks, sampling 1 time unit after each rising edge.
    task automatic step(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(posedge clock);
            #1;
            if (o_valid === 1'b1) pulses++;
        end
    endtask

    initial begin
        int p;

        // sw, cycles, pulses seen, then o_valid/o_busy/o_dir/o_color after the last cycle
        vecs[0]  = '{4'b0001,  2, 0, 1'b0, 1'b0, 1'b0, 3'b001}; // sync latency, still idle
        vecs[1]  = '{4'b0001,  1, 0, 1'b0, 1'b1, 1'b0, 3'b001}; // RUN on third edge
        vecs[2]  = '{4'b0001,  4, 1, 1'b1, 1'b1, 1'b0, 3'b001}; // first pulse
        vecs[3]  = '{4'b0001, 11, 2, 1'b0, 1'b1, 1'b0, 3'b001};
        vecs[4]  = '{4'b0001,  1, 1, 1'b1, 1'b1, 1'b0, 3'b010}; // 4th pulse: green
        vecs[5]  = '{4'b0001, 16, 4, 1'b1, 1'b1, 1'b0, 3'b100}; // 8th pulse: blue
        vecs[6]  = '{4'b0001, 15, 3, 1'b0, 1'b1, 1'b0, 3'b100};
        vecs[7]  = '{4'b0001,  1, 1, 1'b1, 1'b1, 1'b0, 3'b001}; // 12th pulse: red
        vecs[8]  = '{4'b0001,  4, 1, 1'b1, 1'b1, 1'b0, 3'b001}; // 13th pulse
        vecs[9]  = '{4'b0000,  3, 0, 1'b0, 1'b0, 1'b0, 3'b001}; // pause, count held at 3
        vecs[10] = '{4'b0000, 20, 0, 1'b0, 1'b0, 1'b0, 3'b001};
        vecs[11] = '{4'b0001,  3, 0, 1'b0, 1'b1, 1'b0, 3'b001}; // resume
        vecs[12] = '{4'b0001,  1, 1, 1'b1, 1'b1, 1'b0, 3'b001}; // held count finishes
        vecs[13] = '{4'b0001,  1, 0, 1'b0, 1'b1, 1'b0, 3'b001}; // count = 1
        vecs[14] = '{4'b0111,  3, 0, 1'b0, 1'b1, 1'b0, 3'b001}; // clear beats would-be tick
        vecs[15] = '{4'b0111, 31, 0, 1'b0, 1'b1, 1'b0, 3'b001};
        vecs[16] = '{4'b0111,  1, 1, 1'b1, 1'b1, 1'b0, 3'b001}; // 32 after the clear
        vecs[17] = '{4'b0111, 31, 0, 1'b0, 1'b1, 1'b0, 3'b001};
        vecs[18] = '{4'b1111,  1, 1, 1'b1, 1'b1, 1'b0, 3'b010}; // dir too late for this tick
        vecs[19] = '{4'b1111, 32, 1, 1'b1, 1'b1, 1'b1, 3'b010}; // picked up on next tick
        vecs[20] = '{4'b1111, 96, 3, 1'b1, 1'b1, 1'b1, 3'b100};

        i_reset = 1'b0;
        i_sw    = 4'b0000;
        step(3, p);
        check("reset o_valid", {31'd0, o_valid}, 32'd0);
        check("reset o_dir",   {31'd0, o_dir},   32'd0);
        check("reset o_color", {29'd0, o_color}, 32'd1);
        check("reset o_busy",  {31'd0, o_busy},  32'd0);

        i_reset = 1'b1;
        for (int i = 0; i < 21; i++) begin
            i_sw = vecs[i].sw;
            step(vecs[i].n, p);
            check($sformatf("vec%0d pulses", i),  p,                       vecs[i].pulses);
            check($sformatf("vec%0d o_valid", i), {31'd0, o_valid},        {31'd0, vecs[i].valid});
            check($sformatf("vec%0d o_busy", i),  {31'd0, o_busy},         {31'd0, vecs[i].busy});
            check($sformatf("vec%0d o_dir", i),   {31'd0, o_dir},          {31'd0, vecs[i].dir});
            check($sformatf("vec%0d o_color", i), {29'd0, o_color},        {29'd0, vecs[i].color});
        end

        // Asynchronous reset between edges while running on the blue bank.
        step(2, p);
        check("pre-reset o_busy",  {31'd0, o_busy},  32'd1);
        check("pre-reset o_color", {29'd0, o_color}, 32'd4);
        #3;
        i_reset = 1'b0;
        #1;
        check("async o_valid", {31'd0, o_valid}, 32'd0);
        check("async o_dir",   {31'd0, o_dir},   32'd0);
        check("async o_color", {29'd0, o_color}, 32'd1);
        check("async o_busy",  {31'd0, o_busy},  32'd0);
        step(5, p);
        check("held reset pulses", p, 0);
        check("held reset o_busy", {31'd0, o_busy}, 32'd0);

        // Release with enable, speed 3, right; count starts fresh.
        i_reset = 1'b1;
        step(2, p);
        check("release2 o_busy", {31'd0, o_busy}, 32'd0);
        step(1, p);
        check("release3 o_busy", {31'd0, o_busy}, 32'd1);
        step(31, p);
        check("release wait pulses", p, 0);
        step(1, p);
        check("release tick o_valid", {31'd0, o_valid}, 32'd1);
        check("release tick o_dir",   {31'd0, o_dir},   32'd1);
        check("release tick o_color", {29'd0, o_color}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter N_LED, default 4, number of LED positions per bank; shifts per color phase.
REQ-002 Parameter CNT_W, default 24, width of the tick counter.
REQ-003 Parameters LIM0/LIM1/LIM2/LIM3, defaults 2**20/2**21/2**22/2**23, clock cycles per tick for speed codes 0..3; each SHALL satisfy 2 <= LIMn <= 2**CNT_W.
REQ-004 clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-low reset.
REQ-006 i_sw  input  4  raw switches: [0] enable, [2:1] speed code, [3] direction (0 = left, 1 = right).
REQ-007 o_valid  output  1  single-cycle shift strobe to the shift register.
REQ-008 o_dir  output  1  shift direction accompanying o_valid.
REQ-009 o_color  output  3  one-hot bank select {blue,green,red}: 001 = o_led, 010 = o_led_g, 100 = o_led_b.
REQ-010 o_busy  output  1  high while the state is RUN.

Function
REQ-011 i_sw SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value sw_s only.
REQ-012 States SHALL be IDLE, RUN and PAUSE; IDLE is entered only by reset.
REQ-013 Transitions: IDLE->RUN when sw_s[0]=1; RUN->PAUSE when sw_s[0]=0; PAUSE->RUN when sw_s[0]=1; all others hold.
REQ-014 In RUN the tick counter SHALL increment each cycle; when count == LIM(sw_s[2:1])-1 it SHALL wrap to 0 and assert o_valid on the following cycle for exactly one cycle.
REQ-015 In IDLE and PAUSE the counter, shift count and color SHALL hold; o_valid SHALL be 0.
REQ-016 Entering RUN from PAUSE SHALL resume from the held count, not restart it.
REQ-017 A change of sw_s[2:1] SHALL clear the counter to 0 in that cycle, with no tick generated that cycle; the new limit applies from the next cycle.
REQ-018 o_dir SHALL be loaded from sw_s[3] on the same edge that asserts o_valid, and holds otherwise; a direction change never splits or drops a tick.
REQ-019 The shift count (0..N_LED-1) SHALL increment on each tick; on the tick at N_LED-1 it SHALL wrap to 0 and o_color SHALL rotate 001->010->100->001.
REQ-020 The color change and the last shift of a phase SHALL appear on the same cycle as that o_valid.
REQ-021 If disable and the tick condition coincide in one cycle, the tick SHALL be issued and the state then moves to PAUSE.
REQ-022 Counter arithmetic is unsigned CNT_W bits; the count never exceeds LIMn-1.

Reset
REQ-023 i_reset=0 SHALL asynchronously force: state IDLE, counter 0, shift count 0, synchronizer flops 0, o_valid 0, o_dir 0, o_color 001, o_busy 0.
REQ-024 Reset release SHALL be synchronous to clock; the first state change is possible no earlier than 3 cycles after release (2-cycle sync + 1 cycle FSM).
REQ-025 Reset asserted mid-tick SHALL discard the partial count; no o_valid pulse after the asserting edge.

Structure
REQ-026 Shared package led_seq_pkg SHALL hold: state encoding (IDLE/RUN/PAUSE), color one-hot constants, speed-code width, default LIM values.
REQ-027 One sub-module sync_2ff (parameterized width, async active-low reset) SHALL implement REQ-011.
REQ-028 FSM, counter, shift counter and color rotator reside in led_seq_ctrl; expected size 150-300 lines.

Verification (bench overrides LIM0=4, LIM1=8, LIM2=16, LIM3=32, N_LED=4)
REQ-029 Reset then i_sw=0001 -> o_busy high after 3 cycles; o_valid pulses every 4 cycles; o_dir=0; o_color 001 for 4 pulses, then 010.
REQ-030 Run with speed 0 for 13 pulses -> o_color sequence 001,010,100,001; each change coincides with the 4th, 8th and 12th o_valid.
REQ-031 After 2 cycles of counting, set i_sw[0]=0 for 20 cycles, then 1 -> no o_valid while paused; the first pulse after resume arrives 2 counted cycles later (plus sync latency).
REQ-032 Switch speed 0->3 mid-count -> no pulse in the switch cycle; the next pulse arrives 32 cycles after the clear.
REQ-033 Toggle i_sw[3] one cycle before a tick -> the tick is still issued once; o_dir reflects the new value if synchronized by the tick edge, otherwise from the next tick.
REQ-034 Assert i_reset=0 asynchronously between edges while in RUN with o_color=100 -> all outputs return immediately to reset values (o_color 001, o_busy 0).
